// File: rtl/lcd_timing_gen_if.sv
// Raster output bundle of lcd_timing_gen: restart request in, sync/enable,
// coordinates, strobes and frame count out.
interface lcd_timing_gen_if #(
   parameter int CW  = 11,
   parameter int FCW = 16
);
   logic           resync;
   logic           HSYNC;
   logic           VSYNC;
   logic           DATA_EN;
   logic [CW-1:0]  px_x;
   logic [CW-1:0]  px_y;
   logic           line_start;
   logic           frame_start;
   logic           refresh;
   logic [FCW-1:0] frame_cnt;

   modport master (
      input  resync,
      output HSYNC, VSYNC, DATA_EN, px_x, px_y,
      output line_start, frame_start, refresh, frame_cnt
   );

   modport slave (
      output resync,
      input  HSYNC, VSYNC, DATA_EN, px_x, px_y,
      input  line_start, frame_start, refresh, frame_cnt
   );
endinterface

// File: rtl/lcd_timing_gen.sv
// Free-running RGB-LCD raster timing generator with a sync/DE delay line.
// Optional frame counter: define LCD_TIMING_FRAME_CNT_EN.
module lcd_timing_gen #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BP     = 88,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int PIPE_DLY = 0,
   parameter int CW       = 11,
   parameter int FCW      = 16
) (
   input  logic P_CLK,
   input  logic NRST,
   lcd_timing_gen_if.master bus
);
   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_SY_END = CW'(H_SYNC);
   localparam logic [CW-1:0] V_SY_END = CW'(V_SYNC);
   localparam logic [CW-1:0] H_ACT0   = CW'(H_SYNC + H_BP);
   localparam logic [CW-1:0] H_ACT1   = CW'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [CW-1:0] V_ACT0   = CW'(V_SYNC + V_BP);
   localparam logic [CW-1:0] V_ACT1   = CW'(V_SYNC + V_BP + V_ACTIVE);

   // Control vector order: {DATA_EN, VSYNC, HSYNC}, already at output polarity.
   localparam logic [2:0] CTL_IDLE = {1'b0, ~VS_POL, ~HS_POL};

   logic [CW-1:0] h, v;
   logic          h_act, v_act;
   logic          ls_nxt, fs_nxt, rf_nxt;
   logic [2:0]    ctl_nxt, ctl_q, ctl_out;
   logic [CW-1:0] px_x_q, px_y_q;
   logic          ls_q, fs_q, rf_q;

   always_comb begin
      h_act   = (h >= H_ACT0) && (h < H_ACT1);
      v_act   = (v >= V_ACT0) && (v < V_ACT1);
      ls_nxt  = !bus.resync && (h == '0);
      fs_nxt  = ls_nxt && (v == '0);
      rf_nxt  = ls_nxt && (v == V_ACT1);
      ctl_nxt = {h_act && v_act,
                 (v < V_SY_END) ? VS_POL : ~VS_POL,
                 (h < H_SY_END) ? HS_POL : ~HS_POL};
   end

   always_ff @(posedge P_CLK or negedge NRST) begin
      if (!NRST) begin
         h      <= '0;
         v      <= '0;
         ctl_q  <= CTL_IDLE;
         px_x_q <= '0;
         px_y_q <= '0;
         ls_q   <= 1'b0;
         fs_q   <= 1'b0;
         rf_q   <= 1'b0;
      end else begin
         if (bus.resync) begin
            h <= '0;
            v <= '0;
         end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + CW'(1);
         end else begin
            h <= h + CW'(1);
         end
         ctl_q  <= ctl_nxt;
         px_x_q <= (h_act && v_act) ? h - H_ACT0 : '0;
         px_y_q <= v_act ? v - V_ACT0 : '0;
         ls_q   <= ls_nxt;
         fs_q   <= fs_nxt;
         rf_q   <= rf_nxt;
      end
   end

   // Sync/DE delay so pixel data fetched from px_x/px_y lines up with DATA_EN.
   if (PIPE_DLY == 0) begin : g_nodly
      assign ctl_out = ctl_q;
   end else begin : g_dly
      logic [2:0] dly_q [PIPE_DLY];
      always_ff @(posedge P_CLK or negedge NRST) begin
         if (!NRST) begin
            for (int i = 0; i < PIPE_DLY; i++) dly_q[i] <= CTL_IDLE;
         end else begin
            dly_q[0] <= ctl_q;
            for (int i = 1; i < PIPE_DLY; i++) dly_q[i] <= dly_q[i-1];
         end
      end
      assign ctl_out = dly_q[PIPE_DLY-1];
   end

`ifdef LCD_TIMING_FRAME_CNT_EN
   logic [FCW-1:0] fcnt_q;
   always_ff @(posedge P_CLK or negedge NRST) begin
      if (!NRST)       fcnt_q <= '0;
      else if (fs_nxt) fcnt_q <= fcnt_q + FCW'(1);
   end
   assign bus.frame_cnt = fcnt_q;
`else
   assign bus.frame_cnt = '0;
`endif

   assign bus.DATA_EN     = ctl_out[2];
   assign bus.VSYNC       = ctl_out[1];
   assign bus.HSYNC       = ctl_out[0];
   assign bus.px_x        = px_x_q;
   assign bus.px_y        = px_y_q;
   assign bus.line_start  = ls_q;
   assign bus.frame_start = fs_q;
   assign bus.refresh     = rf_q;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a reduced 15x8 raster (120-cycle frame):
// one instance with no delay and active-low syncs, one with PIPE_DLY=2 and active-high syncs.
module tb_lcd_timing_gen;
  localparam int CW  = 5;
  localparam int FCW = 4;
`ifdef LCD_TIMING_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic P_CLK = 1'b0;
  logic NRST  = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;

  // clock / reset
  always #5 P_CLK = ~P_CLK;

  lcd_timing_gen_if #(.CW(CW), .FCW(FCW)) bus0 ();
  lcd_timing_gen_if #(.CW(CW), .FCW(FCW)) bus2 ();

  lcd_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(0), .CW(CW), .FCW(FCW)
  ) u_dut0 (.P_CLK(P_CLK), .NRST(NRST), .bus(bus0));

  lcd_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(2), .CW(CW), .FCW(FCW)
  ) u_dut2 (.P_CLK(P_CLK), .NRST(NRST), .bus(bus2));

  // checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] fc(input int x);
    return FC_EN ? 32'(x) : 32'd0;
  endfunction

  // driver: advance to the negedge after posedge number 'target' since release
  task automatic goto(input int target);
    if (target > k) begin
      repeat (target - k) @(posedge P_CLK);
      @(negedge P_CLK);
      k = target;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hs0"}, bus0.HSYNC, 1);
    chk({tag, "_vs0"}, bus0.VSYNC, 1);
    chk({tag, "_de0"}, bus0.DATA_EN, 0);
    chk({tag, "_px"},  bus0.px_x, 0);
    chk({tag, "_py"},  bus0.px_y, 0);
    chk({tag, "_ls"},  bus0.line_start, 0);
    chk({tag, "_fs"},  bus0.frame_start, 0);
    chk({tag, "_rf"},  bus0.refresh, 0);
    chk({tag, "_fc"},  bus0.frame_cnt, 0);
    chk({tag, "_hs2"}, bus2.HSYNC, 0);
    chk({tag, "_vs2"}, bus2.VSYNC, 0);
    chk({tag, "_de2"}, bus2.DATA_EN, 0);
  endtask

  initial begin
    bus0.resync = 1'b0;
    bus2.resync = 1'b0;
    NRST = 1'b0;
    repeat (10) @(negedge P_CLK);
    chk_reset_vals("rst_hold");

    NRST = 1'b1;
    k = 0;
    chk("rel_hs0", bus0.HSYNC, 1);
    chk("rel_ls", bus0.line_start, 0);

    goto(1);
    chk("k1_hs0", bus0.HSYNC, 0);
    chk("k1_vs0", bus0.VSYNC, 0);
    chk("k1_ls", bus0.line_start, 1);
    chk("k1_fs", bus0.frame_start, 1);
    chk("k1_fc", bus0.frame_cnt, fc(1));
    chk("k1_de0", bus0.DATA_EN, 0);
    chk("k1_hs2", bus2.HSYNC, 0);
    chk("k1_vs2", bus2.VSYNC, 0);
    goto(2);
    chk("k2_hs0", bus0.HSYNC, 0);
    chk("k2_ls", bus0.line_start, 0);
    chk("k2_fs", bus0.frame_start, 0);
    goto(3);
    chk("k3_hs0", bus0.HSYNC, 1);
    chk("k3_hs2", bus2.HSYNC, 1);
    chk("k3_vs2", bus2.VSYNC, 1);
    goto(4);
    chk("k4_hs2", bus2.HSYNC, 1);
    goto(5);
    chk("k5_hs2", bus2.HSYNC, 0);
    goto(15);
    chk("k15_vs0", bus0.VSYNC, 0);
    chk("k15_ls", bus0.line_start, 0);
    goto(16);
    chk("k16_vs0", bus0.VSYNC, 1);
    chk("k16_ls", bus0.line_start, 1);
    chk("k16_hs0", bus0.HSYNC, 0);
    chk("k16_fs", bus0.frame_start, 0);
    goto(17);
    chk("k17_vs2", bus2.VSYNC, 1);
    goto(18);
    chk("k18_vs2", bus2.VSYNC, 0);

    // first active pixel: h=5, v=3 -> state cycle 50
    goto(50);
    chk("k50_de0", bus0.DATA_EN, 0);
    chk("k50_px", bus0.px_x, 0);
    chk("k50_py", bus0.px_y, 0);
    goto(51);
    chk("k51_de0", bus0.DATA_EN, 1);
    chk("k51_px", bus0.px_x, 0);
    chk("k51_py", bus0.px_y, 0);
    chk("k51_de2", bus2.DATA_EN, 0);
    goto(52);
    chk("k52_de2", bus2.DATA_EN, 0);
    chk("k52_px", bus0.px_x, 1);
    goto(53);
    chk("k53_de2", bus2.DATA_EN, 1);
    chk("k53_px2", bus2.px_x, 2);
    goto(58);
    chk("k58_de0", bus0.DATA_EN, 1);
    chk("k58_px", bus0.px_x, 7);
    goto(59);
    chk("k59_de0", bus0.DATA_EN, 0);
    chk("k59_px", bus0.px_x, 0);
    goto(60);
    chk("k60_de2", bus2.DATA_EN, 1);
    goto(61);
    chk("k61_de2", bus2.DATA_EN, 0);
    goto(66);
    chk("k66_de0", bus0.DATA_EN, 1);
    chk("k66_px", bus0.px_x, 0);
    chk("k66_py", bus0.px_y, 1);
    goto(69);
    chk("k69_px", bus0.px_x, 3);
    chk("k69_py", bus0.px_y, 1);

    // first blank line v=7 -> refresh
    goto(105);
    chk("k105_rf", bus0.refresh, 0);
    chk("k105_py", bus0.px_y, 3);
    chk("k105_de0", bus0.DATA_EN, 0);
    goto(106);
    chk("k106_rf", bus0.refresh, 1);
    chk("k106_py", bus0.px_y, 0);
    chk("k106_ls", bus0.line_start, 1);
    goto(107);
    chk("k107_rf", bus0.refresh, 0);

    goto(120);
    chk("k120_fs", bus0.frame_start, 0);
    goto(121);
    chk("k121_fs", bus0.frame_start, 1);
    chk("k121_fc", bus0.frame_cnt, fc(2));
    goto(360);
    chk("k360_fc", bus0.frame_cnt, fc(3));
    chk("k360_fs", bus0.frame_start, 0);
    goto(361);
    chk("k361_fs", bus0.frame_start, 1);
    chk("k361_fc", bus0.frame_cnt, fc(4));

    // resync while counters sit at h=7, v=4
    goto(427);
    bus0.resync = 1'b1;
    bus2.resync = 1'b1;
    goto(428);
    bus0.resync = 1'b0;
    bus2.resync = 1'b0;
    chk("rs_de0", bus0.DATA_EN, 1);
    chk("rs_px", bus0.px_x, 2);
    chk("rs_py", bus0.px_y, 1);
    chk("rs_ls", bus0.line_start, 0);
    chk("rs_fs", bus0.frame_start, 0);
    goto(429);
    chk("rs1_fs", bus0.frame_start, 1);
    chk("rs1_ls", bus0.line_start, 1);
    chk("rs1_hs0", bus0.HSYNC, 0);
    chk("rs1_vs0", bus0.VSYNC, 0);
    chk("rs1_de0", bus0.DATA_EN, 0);
    chk("rs1_px", bus0.px_x, 0);
    chk("rs1_fc", bus0.frame_cnt, fc(5));
    goto(430);
    chk("rs2_de2", bus2.DATA_EN, 1);
    goto(431);
    chk("rs3_de2", bus2.DATA_EN, 0);
    chk("rs3_hs2", bus2.HSYNC, 1);

    // resync landing exactly on the frame origin suppresses the strobes
    goto(548);
    chk("k548_fs", bus0.frame_start, 0);
    bus0.resync = 1'b1;
    bus2.resync = 1'b1;
    goto(549);
    bus0.resync = 1'b0;
    bus2.resync = 1'b0;
    chk("rsw_fs", bus0.frame_start, 0);
    chk("rsw_ls", bus0.line_start, 0);
    chk("rsw_hs0", bus0.HSYNC, 0);
    chk("rsw_fc", bus0.frame_cnt, fc(5));
    goto(550);
    chk("k550_fs", bus0.frame_start, 1);
    chk("k550_fc", bus0.frame_cnt, fc(6));

    // asynchronous reset in the middle of an active line
    goto(600);
    chk("k600_de0", bus0.DATA_EN, 1);
    chk("k600_py", bus0.px_y, 0);
    #2 NRST = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge P_CLK);
    NRST = 1'b1;
    k = 0;
    goto(1);
    chk("rr1_fs", bus0.frame_start, 1);
    chk("rr1_ls", bus0.line_start, 1);
    chk("rr1_hs0", bus0.HSYNC, 0);
    chk("rr1_fc", bus0.frame_cnt, fc(1));
    goto(51);
    chk("rr51_de0", bus0.DATA_EN, 1);
    chk("rr51_px", bus0.px_x, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
